// File: rtl/perceptron_epoch_sequencer_pkg.sv
// Shared types for the perceptron epoch sequencer: FSM states and the default
// sample layout.
package train_pkg;
  localparam int XW_D = 7;
  localparam int TW_D = 2;
  localparam int WW   = 14;

  typedef enum logic [2:0] {
    IDLE, FETCH, LATCH, EVAL, CHECK, UPDATE, NEXT, DONE
  } state_t;

  // Buffer word layout at the default widths; the top packs {x1, x2, t} the same way.
  typedef struct packed {
    logic [XW_D-1:0] x1;
    logic [XW_D-1:0] x2;
    logic [TW_D-1:0] t;
  } sample_t;
endpackage

// File: rtl/perceptron_epoch_sequencer_sample_buffer.sv
// Single-write, registered-read sample RAM. Read data holds until the next read.
module sample_buffer #(
  parameter int DEPTH = 16,
  parameter int DW    = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge Clk)
    if (we) mem[waddr] <= wdata;

  always_ff @(posedge Clk or posedge Rst)
    if (Rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/perceptron_epoch_sequencer.sv
// Epoch sequencer: buffers training samples, then replays them through the
// perceptron datapath with one-hot load/update enables until convergence or EPOCH_MAX.
module perceptron_epoch_sequencer
  import train_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int XW        = XW_D,
  parameter int TW        = TW_D,
  parameter int EPOCH_MAX = 100,
  parameter int EPW       = 8,
  parameter int UPW       = 16
) (
  input  logic           Clk,
  input  logic           Rst,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [XW-1:0]  s_x1,
  input  logic [XW-1:0]  s_x2,
  input  logic [TW-1:0]  s_t,
  input  logic           start,
  input  logic           clr,
  input  logic           TtoY_Flag,
  output logic [XW-1:0]  x1,
  output logic [XW-1:0]  x2,
  output logic [TW-1:0]  t,
  output logic           enx1,
  output logic           enx2,
  output logic           ent,
  output logic           eny,
  output logic           enw1,
  output logic           enw2,
  output logic           enb,
  output logic           busy,
  output logic           done,
  output logic           converged,
  output logic [EPW-1:0] epoch_count,
  output logic [UPW-1:0] update_total
);
  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;
  localparam int DW = 2 * XW + TW;

  state_t        state;
  logic [NW-1:0] n_samples;
  logic [AW-1:0] rd_ptr;
  logic [UPW-1:0] epoch_upd;
  logic [DW-1:0] rdata;
  logic          wr;
  logic [NW-1:0] eff_count;

  assign s_ready   = (state == IDLE || state == DONE) && (n_samples < NW'(DEPTH)) && !Rst;
  assign wr        = s_valid && s_ready;
  assign eff_count = n_samples + NW'(wr);

  sample_buffer #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) u_buf (
    .Clk   (Clk),
    .Rst   (Rst),
    .we    (wr),
    .waddr (n_samples[AW-1:0]),
    .wdata ({s_x1, s_x2, s_t}),
    .re    (state == FETCH),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // The buffer's read register only changes at the end of FETCH, so the
  // datapath operands are valid from LATCH until the next LATCH.
  assign {x1, x2, t} = rdata;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state        <= IDLE;
      n_samples    <= '0;
      rd_ptr       <= '0;
      epoch_upd    <= '0;
      epoch_count  <= '0;
      update_total <= '0;
      {enx1, enx2, ent, eny, enw1, enw2, enb} <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      converged    <= 1'b0;
    end else begin
      {enx1, enx2, ent, eny, enw1, enw2, enb} <= '0;
      case (state)
        IDLE, DONE: begin
          if (wr) n_samples <= n_samples + NW'(1);
          if (clr) begin
            n_samples <= '0;
            done      <= 1'b0;
            converged <= 1'b0;
            state     <= IDLE;
          end else if (start && eff_count != '0) begin
            epoch_count  <= '0;
            update_total <= '0;
            epoch_upd    <= '0;
            rd_ptr       <= '0;
            done         <= 1'b0;
            converged    <= 1'b0;
            busy         <= 1'b1;
            state        <= FETCH;
          end
        end
        FETCH: begin
          {enx1, enx2, ent} <= 3'b111;
          state <= LATCH;
        end
        LATCH: begin
          eny   <= 1'b1;
          state <= EVAL;
        end
        EVAL:  state <= CHECK;
        CHECK: begin
          if (TtoY_Flag) state <= NEXT;
          else begin
            {enw1, enw2, enb} <= 3'b111;
            if (!(&update_total)) update_total <= update_total + UPW'(1);
            if (!(&epoch_upd))    epoch_upd    <= epoch_upd + UPW'(1);
            state <= UPDATE;
          end
        end
        UPDATE: state <= NEXT;
        NEXT: begin
          if ({1'b0, rd_ptr} == n_samples - NW'(1)) begin
            epoch_count <= epoch_count + EPW'(1);
            if (epoch_upd == '0) begin
              converged <= 1'b1;
              done      <= 1'b1;
              busy      <= 1'b0;
              state     <= DONE;
            end else if (epoch_count + EPW'(1) == EPW'(EPOCH_MAX)) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= DONE;
            end else begin
              rd_ptr    <= '0;
              epoch_upd <= '0;
              state     <= FETCH;
            end
          end else begin
            rd_ptr <= rd_ptr + AW'(1);
            state  <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_perceptron_epoch_sequencer.sv
// Directed bench for the epoch sequencer: enable timing, convergence, epoch limit,
// buffer full/clear, start corner cases and mid-update reset.
module tb_perceptron_epoch_sequencer;
  localparam int XW = 7, TW = 2, EPW = 8, UPW = 16;

  logic Clk = 1'b0, Rst = 1'b1;
  logic s_valid = 1'b0, s_ready;
  logic [XW-1:0] s_x1 = '0, s_x2 = '0;
  logic [TW-1:0] s_t = '0;
  logic start = 1'b0, clr = 1'b0, TtoY_Flag = 1'b1;
  logic [XW-1:0] x1, x2;
  logic [TW-1:0] t;
  logic enx1, enx2, ent, eny, enw1, enw2, enb, busy, done, converged;
  logic [EPW-1:0] epoch_count;
  logic [UPW-1:0] update_total;

  int checks = 0, errors = 0;

  logic [XW-1:0] sx1 [4] = '{7'd1, 7'd2, 7'd5, 7'd127};
  logic [XW-1:0] sx2 [4] = '{7'd1, 7'd3, 7'd4, 7'd0};
  logic [TW-1:0] st  [4] = '{2'd1, 2'd1, 2'd0, 2'd2};

  perceptron_epoch_sequencer #(.DEPTH(16), .XW(XW), .TW(TW), .EPOCH_MAX(3),
                               .EPW(EPW), .UPW(UPW)) dut (
    .Clk(Clk), .Rst(Rst), .s_valid(s_valid), .s_ready(s_ready), .s_x1(s_x1),
    .s_x2(s_x2), .s_t(s_t), .start(start), .clr(clr), .TtoY_Flag(TtoY_Flag),
    .x1(x1), .x2(x2), .t(t), .enx1(enx1), .enx2(enx2), .ent(ent), .eny(eny),
    .enw1(enw1), .enw2(enw2), .enb(enb), .busy(busy), .done(done),
    .converged(converged), .epoch_count(epoch_count), .update_total(update_total)
  );

  always #5 Clk = ~Clk;

  function automatic logic [6:0] ens();
    return {enx1, enx2, ent, eny, enw1, enw2, enb};
  endfunction

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1; s_x1 = sx1[i]; s_x2 = sx2[i]; s_t = st[i];
      checks++;
      if (s_ready !== 1'b1) begin errors++; $display("FAIL load_ready i=%0d got %b want 1", i, s_ready); end
      tick();
    end
    s_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++;
    if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", s_ready); end
    checks++;
    if ({busy, done, converged, ens()} !== 10'd0) begin errors++; $display("FAIL rst_flags got %b want 0", {busy, done, converged, ens()}); end
    checks++;
    if ({epoch_count, update_total, x1, x2, t} !== '0) begin errors++; $display("FAIL rst_counts got %h want 0", {epoch_count, update_total, x1, x2, t}); end
    Rst = 1'b0; #1;
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b want 1", s_ready); end
  endtask

  task automatic test_converge();
    logic [6:0] exp;
    load(4);
    TtoY_Flag = 1'b1;
    pulse_start();
    for (int c = 0; c < 20; c++) begin
      exp = (c % 5 == 1) ? 7'h70 : (c % 5 == 2) ? 7'h08 : 7'h00;
      checks++;
      if (ens() !== exp) begin errors++; $display("FAIL conv_en c=%0d got %b want %b", c, ens(), exp); end
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL conv_busy c=%0d got %b want 1", c, busy); end
      if (c % 5 == 1) begin
        checks++;
        if ({x1, x2, t} !== {sx1[c/5], sx2[c/5], st[c/5]})
          begin errors++; $display("FAIL conv_data c=%0d got %h want %h", c, {x1, x2, t}, {sx1[c/5], sx2[c/5], st[c/5]}); end
      end
      tick();
    end
    checks++;
    if ({busy, done, converged} !== 3'b011) begin errors++; $display("FAIL conv_done got %b want 011", {busy, done, converged}); end
    checks++;
    if (epoch_count !== 8'd1 || update_total !== 16'd0)
      begin errors++; $display("FAIL conv_counts got %0d/%0d want 1/0", epoch_count, update_total); end
  endtask

  task automatic test_epoch_limit();
    logic [6:0] exp;
    int cyc = 0;
    TtoY_Flag = 1'b0;
    pulse_start();
    while (busy && cyc < 200) begin
      exp = (cyc % 6 == 1) ? 7'h70 : (cyc % 6 == 2) ? 7'h08 : (cyc % 6 == 4) ? 7'h07 : 7'h00;
      checks++;
      if (ens() !== exp) begin errors++; $display("FAIL lim_en c=%0d got %b want %b", cyc, ens(), exp); end
      cyc++;
      tick();
    end
    checks++;
    if (cyc !== 72) begin errors++; $display("FAIL lim_busy_cycles got %0d want 72", cyc); end
    checks++;
    if ({done, converged} !== 2'b10) begin errors++; $display("FAIL lim_done got %b want 10", {done, converged}); end
    checks++;
    if (epoch_count !== 8'd3 || update_total !== 16'd12)
      begin errors++; $display("FAIL lim_counts got %0d/%0d want 3/12", epoch_count, update_total); end
  endtask

  task automatic test_second_epoch_converge();
    int cyc = 0;
    TtoY_Flag = 1'b0;
    pulse_start();
    while (busy && cyc < 200) begin
      TtoY_Flag = (epoch_count == 0) ? 1'b0 : 1'b1;
      cyc++;
      tick();
    end
    checks++;
    if ({done, converged} !== 2'b11) begin errors++; $display("FAIL ep2_done got %b want 11", {done, converged}); end
    checks++;
    if (epoch_count !== 8'd2 || update_total !== 16'd4)
      begin errors++; $display("FAIL ep2_counts got %0d/%0d want 2/4", epoch_count, update_total); end
  endtask

  task automatic test_buffer_full();
    int hs = 0;
    clr = 1'b1; tick(); clr = 1'b0;
    checks++;
    if ({s_ready, done, converged} !== 3'b100) begin errors++; $display("FAIL clr_state got %b want 100", {s_ready, done, converged}); end
    s_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (s_ready) hs++;
      s_x1 = XW'(i);
      tick();
    end
    checks++;
    if (hs !== 16) begin errors++; $display("FAIL full_handshakes got %0d want 16", hs); end
    checks++;
    if (s_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", s_ready); end
    clr = 1'b1; s_valid = 1'b0; tick(); clr = 1'b0;
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL full_clr_ready got %b want 1", s_ready); end
  endtask

  task automatic test_start_corners();
    int cyc = 0;
    pulse_start();
    checks++;
    if ({busy, ens()} !== 8'd0) begin errors++; $display("FAIL empty_start got %b want 0", {busy, ens()}); end
    tick();
    checks++;
    if ({busy, done} !== 2'b00) begin errors++; $display("FAIL empty_start2 got %b want 00", {busy, done}); end
    load(2);
    TtoY_Flag = 1'b1;
    pulse_start();
    while (!done && cyc < 50) begin cyc++; tick(); end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL corner_run_done got %b want 1", done); end
    clr = 1'b1; start = 1'b1; tick(); clr = 1'b0; start = 1'b0;
    checks++;
    if ({busy, done, converged} !== 3'b000) begin errors++; $display("FAIL clr_start got %b want 000", {busy, done, converged}); end
    tick();
    checks++;
    if ({busy, ens()} !== 8'd0) begin errors++; $display("FAIL clr_start_nofetch got %b want 0", {busy, ens()}); end
  endtask

  task automatic test_reset_mid_update();
    int cyc = 0;
    load(2);
    TtoY_Flag = 1'b0;
    pulse_start();
    while (!enw1 && cyc < 50) begin cyc++; tick(); end
    checks++;
    if ({enw1, enw2, enb} !== 3'b111) begin errors++; $display("FAIL mid_upd_reach got %b want 111", {enw1, enw2, enb}); end
    #2 Rst = 1'b1; #1;
    checks++;
    if (ens() !== 7'd0) begin errors++; $display("FAIL mid_rst_en got %b want 0", ens()); end
    checks++;
    if ({busy, done, converged, s_ready} !== 4'd0) begin errors++; $display("FAIL mid_rst_flags got %b want 0", {busy, done, converged, s_ready}); end
    checks++;
    if ({epoch_count, update_total, x1, x2, t} !== '0) begin errors++; $display("FAIL mid_rst_counts got %h want 0", {epoch_count, update_total, x1, x2, t}); end
    tick();
    Rst = 1'b0;
    pulse_start();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL post_rst_start got %b want 0", busy); end
    load(1);
    pulse_start();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL reload_start got %b want 1", busy); end
  endtask

  initial begin
    test_reset();
    test_converge();
    test_epoch_limit();
    test_second_epoch_converge();
    test_buffer_full();
    test_start_corners();
    test_reset_mid_update();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/perceptron_epoch_sequencer.md
Name: perceptron_epoch_sequencer

Overview:
Controller that schedules the perceptron training datapath (x1/x2/t/y registers, w1/w2/b update) for a whole training set. Samples are streamed in over a valid/ready port and held in a small on-chip buffer. On start, the block replays the buffer epoch after epoch, asserting the datapath load and update enables per sample. It stops on convergence (a full epoch with zero weight updates) or at an epoch limit.

Parameters:
DEPTH, 16, sample buffer entries (power of 2)
XW, 7, width of x1/x2 inputs
TW, 2, width of target t
EPOCH_MAX, 100, maximum epochs before forced stop
EPW, 8, width of epoch counter
UPW, 16, width of total update counter

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  asynchronous reset, active-high
s_valid  in  1  sample offered
s_ready  out  1  sample accepted when s_valid&&s_ready
s_x1  in  XW  sample input 1
s_x2  in  XW  sample input 2
s_t  in  TW  sample target
start  in  1  begin training (pulse)
clr  in  1  empty sample buffer (IDLE/DONE only)
TtoY_Flag  in  1  datapath: y equals t (valid in CHECK)
x1  out  XW  sample to datapath
x2  out  XW  sample to datapath
t  out  TW  target to datapath
enx1, enx2, ent  out  1 each  datapath input-register loads
eny  out  1  datapath output-register load
enw1, enw2, enb  out  1 each  weight/bias update enables
busy  out  1  training in progress
done  out  1  training finished (level)
converged  out  1  valid with done; 1 = zero-update epoch reached
epoch_count  out  EPW  completed epochs
update_total  out  UPW  weight updates issued since start

Behaviour:
- Rst asynchronous: state=IDLE, n_samples=0, rd_ptr=0, all enables 0, x1/x2/t=0, busy=done=converged=0, counters=0.
- States: IDLE, FETCH, LATCH, EVAL, CHECK, UPDATE, NEXT, DONE. Every state except IDLE and DONE lasts exactly 1 cycle.
- s_ready = (state==IDLE || state==DONE) && n_samples<DEPTH && !Rst. An accepted write goes to entry n_samples; n_samples increments.
- IDLE/DONE:
  - clr=1: n_samples=0, done=converged=0, state=IDLE. clr has priority over start.
  - start=1 with effective count>0: the count includes a write accepted the same cycle. Clear epoch_count, update_total, epoch_upd and rd_ptr; done=0; go to FETCH.
  - start with count 0 is ignored.
- FETCH: buffer read at rd_ptr (registered read).
- LATCH: x1/x2/t take the read data. enx1=enx2=ent=1. Outputs stay stable until the next LATCH.
- EVAL: eny=1.
- CHECK: sample TtoY_Flag. 1 → NEXT; 0 → UPDATE.
- UPDATE: enw1=enw2=enb=1. update_total++ (saturating). epoch_upd++ (saturating).
- NEXT, if rd_ptr==n_samples-1 (end of epoch):
  - epoch_count++.
  - epoch_upd==0 → DONE with converged=1.
  - else if epoch_count+1==EPOCH_MAX → DONE with converged=0.
  - else rd_ptr=0, epoch_upd=0, go to FETCH.
- NEXT, otherwise: rd_ptr++, go to FETCH.
- Cycles per sample: 5 without update, 6 with update.
- Enables are registered, one-hot in time, and never overlap.
- busy=1 in FETCH..NEXT. done=1 in DONE and holds until start or clr.
- start, clr and s_valid are ignored while busy.
- The buffer is retained across DONE→start, so a restart replays the same set. The datapath weights are not cleared by this block.
- Rst mid-epoch: all enables drop in the same cycle (asynchronous). Buffer contents become don't-care because n_samples=0.

Decomposition:
- Package train_pkg: state enum, XW/TW defaults, weight width WW=14, sample struct {x1,x2,t}.
- Sub-module sample_buffer: DEPTH×(2·XW+TW) single-write, registered-read RAM with write enable and read address. The FSM and counters stay in the top module.

Test Plan:
1. Load 4 samples (0000001,0000001,01 …), start; TtoY_Flag tied 1.
   → 4×5 enable sequences (enx/ent, then eny, no enw). done=1 on the 21st edge after start. converged=1, epoch_count=1, update_total=0.
2. Same 4 samples with EPOCH_MAX=3; TtoY_Flag tied 0.
   → enw1/enw2/enb pulse once per sample, 72 busy cycles. done=1, converged=0, epoch_count=3, update_total=12.
3. TtoY_Flag=0 only in epoch 1, 1 thereafter.
   → epoch_count=2, update_total=4, converged=1.
4. Offer 17 samples with DEPTH=16.
   → s_ready falls after the 16th handshake; the 17th is held until clr. After clr, n_samples=0 and s_ready=1.
5. start with an empty buffer → stays IDLE, busy=0. clr and start in the same cycle in DONE → IDLE, done=0, no FETCH.
6. Assert Rst during UPDATE → enw1/enw2/enb drop in the same cycle, all outputs reach reset values. After release, start is ignored until samples are reloaded.
